// File: rtl/slf_axi_regs.sv
// slf_axi_regs: AXI4-Lite register block with LED, synchronized inputs, push-button IRQs and scratch.
module slf_axi_regs #(
  parameter int          addr_width = 24,
  parameter logic [31:0] id_value   = 32'h534C_4601
) (
  input  logic                  AXI_S_ACLK,
  input  logic                  AXI_ARESETn,
  input  logic                  AXI_S_AWVALID,
  output logic                  AXI_S_AWREADY,
  input  logic [addr_width-1:0] AXI_S_AWADDR,
  input  logic [2:0]            AXI_S_AWPROT,
  input  logic                  AXI_S_WVALID,
  output logic                  AXI_S_WREADY,
  input  logic [31:0]           AXI_S_WDATA,
  input  logic [3:0]            AXI_S_WSTRB,
  output logic                  AXI_S_BVALID,
  input  logic                  AXI_S_BREADY,
  output logic [1:0]            AXI_S_BRESP,
  input  logic                  AXI_S_ARVALID,
  output logic                  AXI_S_ARREADY,
  input  logic [addr_width-1:0] AXI_S_ARADDR,
  input  logic [2:0]            AXI_S_ARPROT,
  output logic                  AXI_S_RVALID,
  input  logic                  AXI_S_RREADY,
  output logic [31:0]           AXI_S_RDATA,
  output logic [1:0]            AXI_S_RRESP,
  output logic                  INTERRUPT,
  output logic [7:0]            LED,
  input  logic [3:0]            PB,
  input  logic [3:0]            DIP_SW
);
  logic        rdy_q, rdy_d;
  logic        aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic [5:0]  aw_idx_q, aw_idx_d;
  logic [31:0] w_data_q, w_data_d;
  logic [3:0]  w_strb_q, w_strb_d;
  logic        bvalid_q, bvalid_d, rvalid_q, rvalid_d;
  logic [1:0]  bresp_q, bresp_d, rresp_q, rresp_d;
  logic [31:0] rdata_q, rdata_d;
  logic [7:0]  led_q, led_d;
  logic [3:0]  stat_q, stat_d, en_q, en_d;
  logic [31:0] scr_q, scr_d;
  logic [3:0]  pb1_q, pb1_d, pb2_q, pb2_d, pb3_q, pb3_d, dip1_q, dip1_d, dip2_q, dip2_d;
  logic        irq_q, irq_d;
  logic        aw_hs, w_hs, ar_hs, do_wr;
  logic [5:0]  wi, ri;
  logic [31:0] wd, m, rd_val;
  logic [3:0]  ws;
  logic        unused;
  assign unused        = ^{AXI_S_AWPROT, AXI_S_ARPROT, AXI_S_AWADDR, AXI_S_ARADDR};
  assign AXI_S_AWREADY = rdy_q & ~aw_held_q & ~bvalid_q;
  assign AXI_S_WREADY  = rdy_q & ~w_held_q & ~bvalid_q;
  assign AXI_S_ARREADY = rdy_q & ~rvalid_q;
  assign AXI_S_BVALID  = bvalid_q;
  assign AXI_S_BRESP   = bresp_q;
  assign AXI_S_RVALID  = rvalid_q;
  assign AXI_S_RDATA   = rdata_q;
  assign AXI_S_RRESP   = rresp_q;
  assign INTERRUPT     = irq_q;
  assign LED           = led_q;
  // Address and data may arrive in either order; the update fires once both are present.
  always_comb begin
    aw_hs      = AXI_S_AWVALID & AXI_S_AWREADY;
    w_hs       = AXI_S_WVALID & AXI_S_WREADY;
    ar_hs      = AXI_S_ARVALID & AXI_S_ARREADY;
    wi         = aw_held_q ? aw_idx_q : AXI_S_AWADDR[7:2];
    wd         = w_held_q ? w_data_q : AXI_S_WDATA;
    ws         = w_held_q ? w_strb_q : AXI_S_WSTRB;
    do_wr      = (aw_held_q | aw_hs) & (w_held_q | w_hs);
    m          = {{8{ws[3]}}, {8{ws[2]}}, {8{ws[1]}}, {8{ws[0]}}};
    ri         = AXI_S_ARADDR[7:2];
    rd_val     = ri == 6'd0 ? id_value :
                 ri == 6'd1 ? {24'b0, led_q} :
                 ri == 6'd2 ? {24'b0, dip2_q, pb2_q} :
                 ri == 6'd3 ? {28'b0, stat_q} :
                 ri == 6'd4 ? {28'b0, en_q} :
                 ri == 6'd5 ? scr_q : 32'b0;
    rdy_d      = 1'b1;
    aw_held_d  = ~do_wr & (aw_held_q | aw_hs);
    aw_idx_d   = aw_hs ? AXI_S_AWADDR[7:2] : aw_idx_q;
    w_held_d   = ~do_wr & (w_held_q | w_hs);
    w_data_d   = w_hs ? AXI_S_WDATA : w_data_q;
    w_strb_d   = w_hs ? AXI_S_WSTRB : w_strb_q;
    bvalid_d   = do_wr | (bvalid_q & ~AXI_S_BREADY);
    bresp_d    = do_wr ? (wi >= 6'd6 ? 2'b10 : 2'b00) : bresp_q;
    rvalid_d   = ar_hs | (rvalid_q & ~AXI_S_RREADY);
    rdata_d    = ar_hs ? rd_val : rdata_q;
    rresp_d    = ar_hs ? (ri >= 6'd6 ? 2'b10 : 2'b00) : rresp_q;
    led_d      = do_wr && wi == 6'd1 ? (led_q & ~m[7:0]) | (wd[7:0] & m[7:0]) : led_q;
    en_d       = do_wr && wi == 6'd4 ? (en_q & ~m[3:0]) | (wd[3:0] & m[3:0]) : en_q;
    scr_d      = do_wr && wi == 6'd5 ? (scr_q & ~m) | (wd & m) : scr_q;
    stat_d     = (stat_q & ~(do_wr && wi == 6'd3 ? wd[3:0] & m[3:0] : 4'b0)) | (pb2_q & ~pb3_q);
    pb1_d      = PB;
    pb2_d      = pb1_q;
    pb3_d      = pb2_q;
    dip1_d     = DIP_SW;
    dip2_d     = dip1_q;
    irq_d      = |(stat_q & en_q);
  end
  always_ff @(posedge AXI_S_ACLK or negedge AXI_ARESETn) begin
    if (!AXI_ARESETn) begin
      rdy_q     <= 1'b0;
      aw_held_q <= 1'b0;
      aw_idx_q  <= '0;
      w_held_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= '0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= '0;
      led_q     <= '0;
      stat_q    <= '0;
      en_q      <= '0;
      scr_q     <= '0;
      pb1_q     <= '0;
      pb2_q     <= '0;
      pb3_q     <= '0;
      dip1_q    <= '0;
      dip2_q    <= '0;
      irq_q     <= 1'b0;
    end else begin
      rdy_q     <= rdy_d;
      aw_held_q <= aw_held_d;
      aw_idx_q  <= aw_idx_d;
      w_held_q  <= w_held_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      led_q     <= led_d;
      stat_q    <= stat_d;
      en_q      <= en_d;
      scr_q     <= scr_d;
      pb1_q     <= pb1_d;
      pb2_q     <= pb2_d;
      pb3_q     <= pb3_d;
      dip1_q    <= dip1_d;
      dip2_q    <= dip2_d;
      irq_q     <= irq_d;
    end
  end
endmodule

// File: tb/tb_slf_axi_regs.sv
// tb_slf_axi_regs: vector table, corner-case sequences and random traffic against a register-map model.
module tb_slf_axi_regs;
  logic        clk, rst_n;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready, irq;
  logic [23:0] awaddr, araddr;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb, pb, dip;
  logic [1:0]  bresp, rresp;
  logic [7:0]  led;
  int          n_cmp = 0, n_bad = 0;
  logic [7:0]  m_led;
  logic [3:0]  m_stat, m_en;
  logic [31:0] m_scr;
  slf_axi_regs dut (
    .AXI_S_ACLK(clk), .AXI_ARESETn(rst_n),
    .AXI_S_AWVALID(awvalid), .AXI_S_AWREADY(awready), .AXI_S_AWADDR(awaddr), .AXI_S_AWPROT(3'b0),
    .AXI_S_WVALID(wvalid), .AXI_S_WREADY(wready), .AXI_S_WDATA(wdata), .AXI_S_WSTRB(wstrb),
    .AXI_S_BVALID(bvalid), .AXI_S_BREADY(bready), .AXI_S_BRESP(bresp),
    .AXI_S_ARVALID(arvalid), .AXI_S_ARREADY(arready), .AXI_S_ARADDR(araddr), .AXI_S_ARPROT(3'b0),
    .AXI_S_RVALID(rvalid), .AXI_S_RREADY(rready), .AXI_S_RDATA(rdata), .AXI_S_RRESP(rresp),
    .INTERRUPT(irq), .LED(led), .PB(pb), .DIP_SW(dip)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  // lead > 0 presents W that many cycles ahead of AW; bhold keeps BREADY low after BVALID rises.
  task automatic wr(input logic [23:0] a, input logic [31:0] d, input logic [3:0] s,
                    input int lead, input int bhold, output logic [1:0] resp);
    bit ad, wdn;
    logic af, wf;
    int c;
    ad = 0; wdn = 0;
    @(negedge clk);
    wvalid = 1; wdata = d; wstrb = s; awaddr = a;
    if (lead == 0) awvalid = 1;
    for (c = 0; !(ad && wdn) && c < 60; c++) begin
      af = awvalid & awready;
      wf = wvalid & wready;
      @(negedge clk);
      if (af) begin awvalid = 0; ad = 1; end
      if (wf) begin wvalid = 0; wdn = 1; end
      if (c + 1 == lead) awvalid = 1;
    end
    chk("wr_accept", {31'b0, ad && wdn}, 1);
    awvalid = 0; wvalid = 0;
    for (c = 0; !bvalid && c < 20; c++) @(negedge clk);
    chk("bvalid_seen", {31'b0, bvalid}, 1);
    resp = bresp;
    for (int i = 0; i < bhold; i++) begin
      @(negedge clk);
      chk("bhold_valid", {31'b0, bvalid}, 1);
      chk("bhold_resp", {30'b0, bresp}, {30'b0, resp});
      chk("bhold_ready", {30'b0, awready, wready}, 0);
    end
    bready = 1;
    @(negedge clk);
    bready = 0;
    chk("bvalid_drop", {31'b0, bvalid}, 0);
  endtask
  task automatic rd(input logic [23:0] a, output logic [31:0] d, output logic [1:0] r);
    int c;
    @(negedge clk);
    arvalid = 1; araddr = a;
    for (c = 0; c < 20; c++) begin
      if (arready) break;
      @(negedge clk);
    end
    chk("ar_accept", {31'b0, c < 20}, 1);
    @(negedge clk);
    arvalid = 0;
    chk("rvalid_lat", {31'b0, rvalid}, 1);
    d = rdata; r = rresp;
    rready = 1;
    @(negedge clk);
    rready = 0;
    chk("rvalid_drop", {31'b0, rvalid}, 0);
  endtask
  function automatic logic [31:0] m_read(input int idx);
    case (idx)
      0: return 32'h534C_4601;
      1: return {24'b0, m_led};
      2: return {24'b0, dip, 4'b0};
      3: return {28'b0, m_stat};
      4: return {28'b0, m_en};
      5: return m_scr;
      default: return 32'b0;
    endcase
  endfunction
  task automatic m_write(input int idx, input logic [31:0] d, input logic [3:0] s);
    for (int b = 0; b < 4; b++) if (s[b]) begin
      if (idx == 5) m_scr[8*b +: 8] = d[8*b +: 8];
      if (b == 0 && idx == 1) m_led = d[7:0];
      if (b == 0 && idx == 3) m_stat = m_stat & ~d[3:0];
      if (b == 0 && idx == 4) m_en = d[3:0];
    end
  endtask
  typedef struct {
    logic [23:0] a; logic [31:0] d; logic [3:0] s; int lead;
    logic [1:0] br; logic [1:0] rr; logic [31:0] rv; logic [7:0] el;
  } vec_t;
  vec_t tv[12];
  initial begin
    logic [1:0]  r, r2;
    logic [31:0] d;
    tv[0]  = '{24'h000004, 32'h000000A5, 4'b0001, 3, 2'b00, 2'b00, 32'h000000A5, 8'hA5};
    tv[1]  = '{24'h000014, 32'hFFFFFFFF, 4'b0100, 3, 2'b00, 2'b00, 32'h00FF0000, 8'hA5};
    tv[2]  = '{24'h000014, 32'h12345678, 4'b0011, 1, 2'b00, 2'b00, 32'h00FF5678, 8'hA5};
    tv[3]  = '{24'h000010, 32'hFFFFFFFF, 4'b1111, 0, 2'b00, 2'b00, 32'h0000000F, 8'hA5};
    tv[4]  = '{24'h000000, 32'hFFFFFFFF, 4'b1111, 2, 2'b00, 2'b00, 32'h534C4601, 8'hA5};
    tv[5]  = '{24'h00001C, 32'hDEADBEEF, 4'b1111, 0, 2'b10, 2'b10, 32'h00000000, 8'hA5};
    tv[6]  = '{24'h000014, 32'h00000000, 4'b0000, 0, 2'b00, 2'b00, 32'h00FF5678, 8'hA5};
    tv[7]  = '{24'h000104, 32'h0000003C, 4'b0001, 0, 2'b00, 2'b00, 32'h0000003C, 8'h3C};
    tv[8]  = '{24'h000006, 32'h00000011, 4'b0000, 0, 2'b00, 2'b00, 32'h0000003C, 8'h3C};
    tv[9]  = '{24'h000020, 32'h00000001, 4'b1111, 0, 2'b10, 2'b10, 32'h00000000, 8'h3C};
    tv[10] = '{24'h000010, 32'h00000000, 4'b0001, 0, 2'b00, 2'b00, 32'h00000000, 8'h3C};
    tv[11] = '{24'h000008, 32'h000000FF, 4'b1111, 1, 2'b00, 2'b00, 32'h000000A0, 8'h3C};
    rst_n = 0; awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
    awaddr = 0; araddr = 0; wdata = 0; wstrb = 0; pb = 0; dip = 4'hA;
    repeat (3) @(negedge clk);
    chk("rst_ready", {29'b0, awready, wready, arready}, 0);
    chk("rst_valid", {30'b0, bvalid, rvalid}, 0);
    chk("rst_led_irq", {23'b0, led, irq}, 0);
    chk("rst_resp_data", {rdata[27:0], bresp, rresp}, 0);
    rst_n = 1;
    @(negedge clk);
    chk("post_rst_ready", {29'b0, awready, wready, arready}, 3'b111);
    rd(24'h000000, d, r);
    chk("id_data", d, 32'h534C4601);
    chk("id_resp", {30'b0, r}, 0);
    for (int i = 0; i < 12; i++) begin
      wr(tv[i].a, tv[i].d, tv[i].s, tv[i].lead, 0, r);
      chk($sformatf("tv%0d_bresp", i), {30'b0, r}, {30'b0, tv[i].br});
      chk($sformatf("tv%0d_led", i), {24'b0, led}, {24'b0, tv[i].el});
      rd(tv[i].a, d, r);
      chk($sformatf("tv%0d_rdata", i), d, tv[i].rv);
      chk($sformatf("tv%0d_rresp", i), {30'b0, r}, {30'b0, tv[i].rr});
    end
    wr(24'h000010, 32'h1, 4'b0001, 0, 0, r);
    @(negedge clk); pb = 4'b0001;
    repeat (4) @(negedge clk);
    pb = 0;
    rd(24'h00000C, d, r);
    chk("irq_status_set", d, 32'h1);
    repeat (2) @(negedge clk);
    chk("irq_high", {31'b0, irq}, 1);
    wr(24'h00000C, 32'h1, 4'b0001, 0, 0, r);
    @(negedge clk);
    chk("irq_cleared", {31'b0, irq}, 0);
    rd(24'h00000C, d, r);
    chk("irq_status_clr", d, 32'h0);
    @(negedge clk); pb = 4'b0001;
    @(negedge clk);
    wr(24'h00000C, 32'h1, 4'b0001, 0, 0, r);
    rd(24'h00000C, d, r);
    chk("irq_set_wins", d, 32'h1);
    pb = 0;
    repeat (3) @(negedge clk);
    chk("irq_after_race", {31'b0, irq}, 1);
    wr(24'h00000C, 32'hF, 4'b0001, 0, 0, r);
    wr(24'h000010, 32'h0, 4'b0001, 0, 0, r);
    fork
      wr(24'h000014, 32'hCAFEF00D, 4'b1111, 0, 0, r2);
      rd(24'h000014, d, r);
    join
    chk("concurrent_prewrite", d, 32'h00FF5678);
    rd(24'h000014, d, r);
    chk("concurrent_postwrite", d, 32'hCAFEF00D);
    wr(24'h000004, 32'h77, 4'b0001, 0, 5, r);
    chk("bhold_final_resp", {30'b0, r}, 0);
    wr(24'h000004, 32'h5A, 4'b0001, 0, 0, r);
    chk("second_write_led", {24'b0, led}, 32'h5A);
    @(negedge clk);
    arvalid = 1; araddr = 24'h000004;
    @(negedge clk);
    arvalid = 0;
    @(negedge clk);
    chk("pre_rst_rvalid", {31'b0, rvalid}, 1);
    #2 rst_n = 0;
    #1;
    chk("rst_rvalid_drop", {31'b0, rvalid}, 0);
    chk("rst_led_clear", {24'b0, led}, 0);
    chk("rst_arready", {31'b0, arready}, 0);
    @(negedge clk); rst_n = 1;
    @(negedge clk);
    chk("rerst_ready", {29'b0, awready, wready, arready}, 3'b111);
    rd(24'h000004, d, r);
    chk("rerst_led_read", d, 0);
    m_led = 0; m_stat = 0; m_en = 0; m_scr = 0;
    for (int i = 0; i < 250; i++) begin
      int idx;
      logic [23:0] a;
      logic [31:0] wd;
      logic [3:0]  s;
      idx = $urandom_range(0, 9);
      a = 24'($urandom);
      a[7:2] = 6'(idx);
      if ($urandom_range(0, 1) == 1) begin
        wd = $urandom;
        s = 4'($urandom);
        wr(a, wd, s, $urandom_range(0, 3), 0, r);
        m_write(idx, wd, s);
        chk("rnd_bresp", {30'b0, r}, idx >= 6 ? 32'd2 : 32'd0);
        chk("rnd_led", {24'b0, led}, {24'b0, m_led});
      end else begin
        rd(a, d, r);
        chk("rnd_rdata", d, m_read(idx));
        chk("rnd_rresp", {30'b0, r}, idx >= 6 ? 32'd2 : 32'd0);
      end
    end
    chk("rnd_irq", {31'b0, irq}, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/slf_axi_regs.md
SLF_AXI_REGS -- requirements
Module: slf_axi_regs

Interface
REQ-001 SHALL have parameter addr_width, default 24, meaning AXI register address width.
REQ-002 SHALL have parameter id_value, default 32'h534C_4601, meaning the value read from the ID register.
REQ-003 SHALL have ports:
- AXI_S_ACLK  in  1  the only clock; all logic is on its rising edge.
- AXI_ARESETn  in  1  asynchronous, active-low reset.
REQ-004 SHALL have AXI write-channel ports:
- AXI_S_AWVALID in 1; AXI_S_AWREADY out 1; AXI_S_AWADDR in addr_width; AXI_S_AWPROT in 3 (ignored).
- AXI_S_WVALID in 1; AXI_S_WREADY out 1; AXI_S_WDATA in 32; AXI_S_WSTRB in 4.
- AXI_S_BVALID out 1; AXI_S_BREADY in 1; AXI_S_BRESP out 2.
REQ-005 SHALL have AXI read-channel ports:
- AXI_S_ARVALID in 1; AXI_S_ARREADY out 1; AXI_S_ARADDR in addr_width; AXI_S_ARPROT in 3 (ignored).
- AXI_S_RVALID out 1; AXI_S_RREADY in 1; AXI_S_RDATA out 32; AXI_S_RRESP out 2.
REQ-006 SHALL have ports INTERRUPT out 1 (level irq); LED out 8; PB in 4 (async push buttons); DIP_SW in 4 (async switches).

Function
REQ-007 Register map, decoded on addr[7:2]; addr bits above 7 and bits [1:0] ignored:
- 0x00 ID, RO = id_value.
- 0x04 LED, RW [7:0].
- 0x08 INPUTS, RO {24'b0, DIP_SW_sync, PB_sync}.
- 0x0C IRQ_STATUS, RW1C [3:0].
- 0x10 IRQ_ENABLE, RW [3:0].
- 0x14 SCRATCH, RW 32 bits.
REQ-008 Writes SHALL honour WSTRB per byte lane; unimplemented bits read 0.
REQ-009 Writes to ID and INPUTS SHALL be ignored with BRESP=00; offsets >= 0x18 SHALL give SLVERR (10) for reads and writes, with RDATA=0.
REQ-010 AWREADY SHALL be 1 iff no address is held and BVALID=0; WREADY SHALL be 1 iff no data is held and BVALID=0.
REQ-011 AW and W SHALL be accepted independently, in either order or in the same cycle.
REQ-012 The register update SHALL occur on the edge where both address and data are available (held or handshaking); BVALID SHALL rise on the next cycle, with holds cleared.
REQ-013 BVALID/BRESP SHALL stay stable until the BREADY handshake; BVALID SHALL drop on the edge with BREADY=1.
REQ-014 ARREADY SHALL equal !RVALID; on the AR handshake, RDATA/RRESP SHALL be registered and RVALID=1 the next cycle (1-cycle latency).
REQ-015 RVALID/RDATA/RRESP SHALL stay stable until RREADY; RVALID SHALL drop on the edge with RREADY=1.
REQ-016 Read and write paths SHALL operate concurrently; a read of a register written in the same cycle SHALL return the pre-write value.
REQ-017 PB and DIP_SW SHALL pass through 2-flop synchronizers; INPUTS SHALL return the synchronized values.
REQ-018 A 0->1 transition of synchronized PB[i] SHALL set IRQ_STATUS[i]; writing 1 to a bit SHALL clear it; when set and clear coincide, set SHALL win.
REQ-019 INTERRUPT SHALL be registered: |(IRQ_STATUS & IRQ_ENABLE), one cycle after the status/enable change.
REQ-020 LED output SHALL equal the LED register directly.

Reset
REQ-021 While AXI_ARESETn=0 (asynchronously), the block SHALL hold: AWREADY, WREADY, ARREADY, BVALID, RVALID, INTERRUPT = 0; BRESP, RRESP, RDATA = 0; LED, IRQ_STATUS, IRQ_ENABLE, SCRATCH = 0; synchronizers = 0; no address or data held.
REQ-022 Reset mid-transaction SHALL discard pending AW/W/B/R state; AWREADY, WREADY and ARREADY SHALL rise in the first cycle after deassertion.
REQ-023 Synchronizer reset SHALL NOT cause a spurious PB edge after deassertion when PB=0.

Verification
REQ-024 Read 0x00 -> RVALID one cycle after AR handshake, RDATA=0x534C4601, RRESP=00.
REQ-025 W presented 3 cycles before AW: write 0x04 with data 0xA5, WSTRB=0001 -> BRESP=00, LED=0xA5; write 0x14 with data 0xFFFFFFFF, WSTRB=0100 -> readback 0x00FF0000.
REQ-026 BREADY held low 5 cycles -> BVALID and BRESP stay stable, AWREADY=WREADY=0 throughout; a second write is accepted only after the B handshake.
REQ-027 IRQ_ENABLE=0x1, pulse PB[0] -> IRQ_STATUS=0x1, INTERRUPT=1; write 0x1 to 0x0C -> INTERRUPT=0; a PB[0] edge coinciding with the clear leaves status=1.
REQ-028 Read 0x20 -> RRESP=10, RDATA=0; write 0x1C -> BRESP=10, no register changes.
REQ-029 Assert reset while RVALID=1 and RREADY=0 -> RVALID=0 immediately, LED=0; after release, a read of 0x04 returns 0.
